// File: rtl/enemy_ship.sv
// Enemy ship: a box that sweeps left/right, drops a row at each side wall,
// explodes when the player bullet overlaps it, and respawns at an LFSR-chosen column.
module enemy_ship #(
   parameter int         H_SIZE         = 16,
   parameter int         SPEED          = 2,
   parameter int         DROP           = 8,
   parameter int         EXPLODE_FRAMES = 30,
   parameter logic [9:0] SEED           = 10'h2A5
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_ani_stb,
   input  logic        i_animate,
   input  logic        i_paused,
   input  logic [11:0] i_bx1,
   input  logic [11:0] i_bx2,
   input  logic [11:0] i_by1,
   input  logic [11:0] i_by2,
   input  logic        i_firing,
   output logic [11:0] o_x1,
   output logic [11:0] o_x2,
   output logic [11:0] o_y1,
   output logic [11:0] o_y2,
   output logic        o_alive,
   output logic        o_exploding,
   output logic        o_hit,
   output logic        o_breach,
   output logic [7:0]  o_score
);

   localparam logic [11:0] HS       = 12'(H_SIZE);
   localparam logic [11:0] SP       = 12'(SPEED);
   localparam logic [11:0] DR       = 12'(DROP);
   localparam logic [11:0] X_MAX    = 12'd639;
   localparam logic [11:0] Y_MAX    = 12'd479;
   localparam logic [11:0] X_RST    = 12'd320;
   localparam logic [11:0] X_RIGHT  = 12'(639 - H_SIZE);
   localparam logic [11:0] LEFT_LIM = 12'(H_SIZE + SPEED);
   localparam logic [11:0] RNG      = 12'(640 - 2 * H_SIZE);
   localparam logic [7:0]  EXP_LAST = 8'(EXPLODE_FRAMES - 1);

   typedef enum logic [1:0] {ALIVE, EXPLODE, RESPAWN} state_t;

   state_t      state, state_n;
   logic [11:0] x, x_n, y, y_n, y_drop, lfsr_ext;
   logic        dir, dir_n, drop, tick, overlap;
   logic [7:0]  cnt, cnt_n, score_n;
   logic [9:0]  lfsr, lfsr_n;
   logic        hit_n, breach_n;

   assign tick     = i_ani_stb & i_animate & ~i_paused;
   assign y_drop   = y + DR;
   assign lfsr_ext = {2'b00, lfsr};
   assign lfsr_n   = {lfsr[8:0], lfsr[9] ^ lfsr[6]};
   // Overlap is tested against the registered box, i.e. what is on screen now
   assign overlap  = i_firing & (i_bx1 < o_x2) & (i_bx2 > o_x1) &
                     (i_by1 < o_y2) & (i_by2 > o_y1);

   assign o_alive     = (state == ALIVE);
   assign o_exploding = (state == EXPLODE);

   always_comb begin
      state_n  = state;
      x_n      = x;
      y_n      = y;
      dir_n    = dir;
      cnt_n    = cnt;
      score_n  = o_score;
      hit_n    = 1'b0;
      breach_n = 1'b0;
      drop     = 1'b0;
      case (state)
         ALIVE: begin
            if (!i_paused && overlap) begin
               hit_n   = 1'b1;
               score_n = (o_score == 8'hFF) ? o_score : o_score + 8'd1;
               cnt_n   = '0;
               state_n = EXPLODE;
            end else if (tick) begin
               if (dir) begin
                  if (x + HS + SP > X_MAX) begin
                     x_n   = X_RIGHT;
                     dir_n = 1'b0;
                     drop  = 1'b1;
                  end else begin
                     x_n = x + SP;
                  end
               end else begin
                  if (x < LEFT_LIM) begin
                     x_n   = HS;
                     dir_n = 1'b1;
                     drop  = 1'b1;
                  end else begin
                     x_n = x - SP;
                  end
               end
               if (drop) begin
                  y_n = y_drop;
                  if (y_drop + HS > Y_MAX) begin
                     breach_n = 1'b1;
                     state_n  = RESPAWN;
                  end
               end
            end
         end
         EXPLODE: begin
            if (tick) begin
               if (cnt == EXP_LAST) state_n = RESPAWN;
               else                 cnt_n   = cnt + 8'd1;
            end
         end
         RESPAWN: begin
            if (!i_paused) begin
               x_n     = HS + ((lfsr_ext < RNG) ? lfsr_ext : lfsr_ext - RNG);
               y_n     = HS;
               dir_n   = 1'b1;
               state_n = ALIVE;
            end
         end
         default: state_n = ALIVE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= ALIVE;
         x        <= X_RST;
         y        <= HS;
         dir      <= 1'b1;
         cnt      <= '0;
         lfsr     <= SEED;
         o_score  <= '0;
         o_hit    <= 1'b0;
         o_breach <= 1'b0;
         o_x1     <= X_RST - HS;
         o_x2     <= X_RST + HS;
         o_y1     <= '0;
         o_y2     <= HS + HS;
      end else begin
         state    <= state_n;
         x        <= x_n;
         y        <= y_n;
         dir      <= dir_n;
         cnt      <= cnt_n;
         lfsr     <= lfsr_n;
         o_score  <= score_n;
         o_hit    <= hit_n;
         o_breach <= breach_n;
         o_x1     <= x - HS;
         o_x2     <= x + HS;
         o_y1     <= y - HS;
         o_y2     <= y + HS;
      end
   end

endmodule

// File: tb/tb_enemy_ship.sv
// Randomized scoreboard bench for enemy_ship: a frame-level game model predicts
// every clock's outputs; a monitor pops and compares them one cycle later.
module tb_enemy_ship;

   logic        i_clk = 1'b0, i_rst_n = 1'b0;
   logic        i_ani_stb = 1'b0, i_animate = 1'b0, i_paused = 1'b0, i_firing = 1'b0;
   logic [11:0] i_bx1 = '0, i_bx2 = '0, i_by1 = '0, i_by2 = '0;
   logic [11:0] o_x1, o_x2, o_y1, o_y2;
   logic        o_alive, o_exploding, o_hit, o_breach;
   logic [7:0]  o_score;

   enemy_ship dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ani_stb(i_ani_stb), .i_animate(i_animate),
      .i_paused(i_paused), .i_bx1(i_bx1), .i_bx2(i_bx2), .i_by1(i_by1), .i_by2(i_by2),
      .i_firing(i_firing), .o_x1(o_x1), .o_x2(o_x2), .o_y1(o_y1), .o_y2(o_y2),
      .o_alive(o_alive), .o_exploding(o_exploding), .o_hit(o_hit), .o_breach(o_breach),
      .o_score(o_score)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int x1, x2, y1, y2, score;
      bit alive, expl, hit, breach;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Game model: centre position, heading, phase (0 flying, 1 exploding, 2 respawning)
   int mx, my, mdir, mphase, mframes, ml, mscore, ex1, ex2, ey1, ey2;

   task automatic model_reset();
      mx = 320; my = 16; mdir = 1; mphase = 0; mframes = 0; ml = 'h2A5; mscore = 0;
      ex1 = 304; ex2 = 336; ey1 = 0; ey2 = 32;
   endtask

   task automatic chk(input string name, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   // Called at a negedge: apply inputs, predict the next posedge, wait for the next negedge.
   task automatic drive(input bit stb, input bit anim, input bit pau, input bit fire,
                        input bit aim, input int b1, input int b2, input int b3, input int b4);
      exp_t e;
      bit   tick, hit, breach, bounced;
      int   nx1, nx2, ny1, ny2;
      if (aim) begin
         b1 = ex1 + 1; b2 = ex1 + 5; b3 = ey1 + 1; b4 = ey1 + 5;
      end
      i_ani_stb = stb; i_animate = anim; i_paused = pau; i_firing = fire;
      i_bx1 = 12'(b1); i_bx2 = 12'(b2); i_by1 = 12'(b3); i_by2 = 12'(b4);
      tick = stb && anim && !pau;
      nx1 = mx - 16; nx2 = mx + 16; ny1 = my - 16; ny2 = my + 16;
      hit = 0; breach = 0; bounced = 0;
      if (!pau) begin
         if (mphase == 0) begin
            if (fire && b1 < ex2 && b2 > ex1 && b3 < ey2 && b4 > ey1) begin
               hit = 1;
               if (mscore < 255) mscore++;
               mframes = 0;
               mphase = 1;
            end else if (tick) begin
               if (mdir == 1 && mx + 18 > 639) begin
                  mx = 623; mdir = 0; bounced = 1;
               end else if (mdir == 0 && mx < 18) begin
                  mx = 16; mdir = 1; bounced = 1;
               end else begin
                  mx = (mdir == 1) ? mx + 2 : mx - 2;
               end
               if (bounced) begin
                  my += 8;
                  if (my + 16 > 479) begin
                     breach = 1;
                     mphase = 2;
                  end
               end
            end
         end else if (mphase == 1) begin
            if (tick) begin
               mframes++;
               if (mframes == 30) mphase = 2;
            end
         end else begin
            mx = 16 + ((ml < 608) ? ml : ml - 608);
            my = 16; mdir = 1; mphase = 0;
         end
      end
      ml = ((ml << 1) & 1023) | (((ml >> 9) ^ (ml >> 6)) & 1);
      ex1 = nx1; ex2 = nx2; ey1 = ny1; ey2 = ny2;
      e.x1 = nx1; e.x2 = nx2; e.y1 = ny1; e.y2 = ny2; e.score = mscore;
      e.alive = (mphase == 0); e.expl = (mphase == 1); e.hit = hit; e.breach = breach;
      q.push_back(e);
      @(negedge i_clk);
   endtask

   task automatic drive_rand();
      int b1, b3;
      b1 = int'($urandom % 636);
      b3 = int'($urandom % 476);
      drive(($urandom % 4) != 0, ($urandom % 2) != 0, ($urandom % 8) == 0,
            ($urandom % 2) != 0, ($urandom % 3) == 0,
            b1, b1 + 1 + int'($urandom % 8), b3, b3 + 1 + int'($urandom % 8));
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 20) begin
         @(posedge i_clk); #2; n++;
      end
      if (q.size() > 0) chk("scoreboard_drain_timeout", q.size(), 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_x1"}, int'(o_x1), 304);
      chk({tag, "_x2"}, int'(o_x2), 336);
      chk({tag, "_y1"}, int'(o_y1), 0);
      chk({tag, "_y2"}, int'(o_y2), 32);
      chk({tag, "_alive"}, int'(o_alive), 1);
      chk({tag, "_exploding"}, int'(o_exploding), 0);
      chk({tag, "_hit"}, int'(o_hit), 0);
      chk({tag, "_breach"}, int'(o_breach), 0);
      chk({tag, "_score"}, int'(o_score), 0);
   endtask

   // Monitor: one scoreboard entry per clock while stimulus is running
   initial begin
      exp_t e;
      forever begin
         @(posedge i_clk); #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if (int'(o_x1) != e.x1 || int'(o_x2) != e.x2 || int'(o_y1) != e.y1 ||
                int'(o_y2) != e.y2 || o_alive != e.alive || o_exploding != e.expl ||
                o_hit != e.hit || o_breach != e.breach || int'(o_score) != e.score) begin
               n_fail++;
               $display("FAIL cycle t=%0t: got box %0d,%0d,%0d,%0d a%0d e%0d h%0d b%0d s%0d; expected box %0d,%0d,%0d,%0d a%0d e%0d h%0d b%0d s%0d",
                        $time, o_x1, o_x2, o_y1, o_y2, o_alive, o_exploding, o_hit, o_breach, o_score,
                        e.x1, e.x2, e.y1, e.y2, e.alive, e.expl, e.hit, e.breach, e.score);
            end
         end
      end
   end

   initial begin
      int guard;
      model_reset();
      #23;
      chk_reset_outputs("reset");
      // Overlapping bullet held during reset must not register a hit
      i_firing = 1'b1; i_bx1 = 12'd310; i_bx2 = 12'd320; i_by1 = 12'd5; i_by2 = 12'd10;
      @(posedge i_clk); #1;
      chk("reset_hit_blocked", int'(o_hit), 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // Basic motion: 10 ticks then one idle clock so the box catches up
      for (int i = 0; i < 10; i++) drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("motion_x1", int'(o_x1), 324);
      chk("motion_x2", int'(o_x2), 356);
      chk("motion_y1", int'(o_y1), 0);
      chk("motion_alive", int'(o_alive), 1);

      // Pause with an overlapping bullet and running strobes
      for (int i = 0; i < 5; i++) drive(1, 1, 1, 1, 1, 0, 0, 0, 0);
      chk("pause_no_hit", int'(o_hit), 0);
      chk("pause_x1_held", int'(o_x1), 324);
      // Release: hit on the very next clock, beating the simultaneous tick
      drive(1, 1, 0, 1, 1, 0, 0, 0, 0);
      chk("hit_pulse", int'(o_hit), 1);
      chk("hit_score", int'(o_score), 1);
      chk("hit_alive", int'(o_alive), 0);
      chk("hit_exploding", int'(o_exploding), 1);
      drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("hit_one_cycle", int'(o_hit), 0);
      chk("hit_no_move_x1", int'(o_x1), 324);
      for (int i = 0; i < 28; i++) drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("explode_29_ticks", int'(o_exploding), 1);
      drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("explode_done", int'(o_exploding), 0);
      chk("respawn_not_alive", int'(o_alive), 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("respawn_alive", int'(o_alive), 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("respawn_y1", int'(o_y1), 0);
      chk("respawn_x_range", int'(o_x1 <= 12'd607), 1);

      // Mixed random play
      for (int i = 0; i < 2000; i++) drive_rand();

      // Long uninterrupted flight: many wall bounces down to a bottom breach
      for (int i = 0; i < 21000; i++)
         drive(1, 1, ($urandom % 50) == 0, 0, 0, 0, 0, 0, 0);

      // Repeated aimed hits until the score saturates, plus some beyond
      guard = 0;
      while (mscore < 255 && guard < 12000) begin
         drive(1, 1, 0, 1, 1, 0, 0, 0, 0);
         guard++;
      end
      for (int i = 0; i < 200; i++) drive(1, 1, 0, 1, 1, 0, 0, 0, 0);
      chk("score_saturated", int'(o_score), 255);

      // Reset asserted mid-explosion takes effect without a clock
      guard = 0;
      while (mphase != 1 && guard < 100) begin
         drive(1, 1, 0, 1, 1, 0, 0, 0, 0);
         guard++;
      end
      for (int i = 0; i < 10; i++) drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
      drain();
      chk("pre_reset_exploding", int'(o_exploding), 1);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk_reset_outputs("async_reset");
      i_firing = 1'b1; i_bx1 = 12'd310; i_bx2 = 12'd320; i_by1 = 12'd5; i_by2 = 12'd10;
      @(posedge i_clk); #1;
      chk("reset_overrides_hit", int'(o_hit), 0);
      chk("reset_score_held", int'(o_score), 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 300; i++) drive_rand();
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/enemy_ship.md
ENEMY_SHIP -- requirements
Module: enemy_ship

Interface
- REQ-001 Parameter H_SIZE, default 16: half-size of the square enemy box in pixels; legal range 4..100.
- REQ-002 Parameter SPEED, default 2: horizontal step per frame tick in pixels.
- REQ-003 Parameter DROP, default 8: vertical step applied at each side-wall bounce.
- REQ-004 Parameter EXPLODE_FRAMES, default 30: number of frame ticks spent in EXPLODE.
- REQ-005 Parameter SEED, default 10'h2A5: LFSR reset value; must be nonzero.
- REQ-006 Clock and reset: one clock; reset is asynchronous and active-low.
- REQ-007 i_clk, input, 1: system clock (100 MHz).
- REQ-008 i_rst_n, input, 1: asynchronous active-low reset.
- REQ-009 i_ani_stb, input, 1: pixel strobe, one cycle wide.
- REQ-010 i_animate, input, 1: end-of-frame indicator.
- REQ-011 i_paused, input, 1: game paused.
- REQ-012 i_bx1, i_bx2, i_by1, i_by2, input, 12 each: player bullet box.
- REQ-013 i_firing, input, 1: bullet in flight.
- REQ-014 o_x1, o_x2, o_y1, o_y2, output, 12 each: enemy box edges.
- REQ-015 o_alive, output, 1: enemy drawable and hittable.
- REQ-016 o_exploding, output, 1: explosion in progress.
- REQ-017 o_hit, output, 1: one-cycle pulse when the bullet hits; the ship block consumes it to cancel the bullet.
- REQ-018 o_breach, output, 1: one-cycle pulse when the enemy reaches the bottom of the screen.
- REQ-019 o_score, output, 8: hit count, saturating.

Function
- REQ-020 Frame tick definition: tick = i_ani_stb & i_animate & ~i_paused.
- REQ-021 Position registers: internal centre x and y, 12 bits each, plus a direction bit (1 = right).
- REQ-022 Box outputs: o_x1 = x-H_SIZE, o_x2 = x+H_SIZE, o_y1 = y-H_SIZE, o_y2 = y+H_SIZE; registered, updated the cycle after x/y change.
- REQ-023 States: ALIVE, EXPLODE, RESPAWN.
  - o_alive = (state==ALIVE).
  - o_exploding = (state==EXPLODE).
- REQ-024 ALIVE, tick, moving right:
  - if x+H_SIZE+SPEED > 639: x = 639-H_SIZE, direction = left, y += DROP;
  - else x += SPEED.
- REQ-025 ALIVE, tick, moving left:
  - if x < H_SIZE+SPEED: x = H_SIZE, direction = right, y += DROP;
  - else x -= SPEED.
- REQ-026 Bottom breach: if a drop makes y+H_SIZE > 479, pulse o_breach for one cycle and go to RESPAWN; o_score is unchanged.
- REQ-027 Hit condition, evaluated every clock in ALIVE with i_paused=0 and i_firing=1: i_bx1 < o_x2, i_bx2 > o_x1, i_by1 < o_y2, i_by2 > o_y1.
- REQ-028 On a hit:
  - o_hit pulses one cycle.
  - o_score increments, saturating at 255.
  - Explode counter loads 0 and state goes to EXPLODE.
- REQ-029 Hit and tick in the same cycle: the hit wins and no movement occurs.
- REQ-030 EXPLODE: the counter increments on each tick; when it reaches EXPLODE_FRAMES-1 and a tick occurs, go to RESPAWN. Position is frozen.
- REQ-031 LFSR: 10-bit Fibonacci, taps x^10+x^7, advances every clock including while paused.
- REQ-032 RESPAWN lasts one cycle; on exit:
  - x = H_SIZE + (L < R ? L : L-R), where L = LFSR value and R = 640-2*H_SIZE;
  - y = H_SIZE, direction = right, state = ALIVE.
- REQ-033 Pause: while i_paused=1, position, counter, state and hit detection all hold; no pulses are issued.
- REQ-034 Arithmetic: all position arithmetic is unsigned 12-bit; the bounds above guarantee no underflow or overflow.

Reset
- REQ-035 Asynchronous assertion of i_rst_n=0 takes effect at any time, including mid-EXPLODE, and overrides any simultaneous hit.
- REQ-036 Reset values:
  - x=320, y=H_SIZE, direction right, state ALIVE, counter 0, LFSR=SEED, o_score=0, o_hit=0, o_breach=0;
  - o_x1=304, o_x2=336, o_y1=0, o_y2=32 (defaults).
- REQ-037 Synchronous deassertion is required of the integrator; the block has no internal synchronizer.

Verification (defaults)
- REQ-038 Basic motion: release reset, apply 10 ticks, no bullet -> x=340, o_x1=324, o_x2=356, y=16, o_alive=1.
- REQ-039 Right-wall bounce: force x=620 right, then 2 ticks -> x=622, then x=623, direction left, y=24.
- REQ-040 Hit: bullet box (330,10)-(334,20) with i_firing=1 -> o_hit high exactly 1 cycle, o_score=1, o_alive=0, o_exploding=1.
  - 29 ticks later still exploding.
  - 30th tick -> RESPAWN, then ALIVE with y=16 and H_SIZE ≤ x ≤ 623.
- REQ-041 Pause: hold i_paused=1 with a bullet overlapping and animate strobes running -> no o_hit, position unchanged; release -> hit is detected on the next clock.
- REQ-042 Breach: y=464 moving right at the wall, one tick -> o_breach 1 cycle, o_score unchanged, respawn at y=16.
- REQ-043 Saturation and reset mid-operation: 256 hits -> o_score=255; assert i_rst_n=0 during EXPLODE -> all outputs at reset values immediately, without waiting for a clock.
